// File: rtl/uart_pkg.sv
// Shared UART definitions: baud/parity encodings, receiver FSM states and the
// oversample divisor helper.
package uart_pkg;

  localparam int unsigned OS_RATE = 16;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_e;

  // Clocks per oversample tick, truncated; never below 1 so the tick still runs.
  function automatic int unsigned baud_divisor(input logic [1:0] baud,
                                               input int unsigned clk_freq);
    int unsigned rate;
    int unsigned div;
    case (baud)
      BAUD_2400: rate = 2400;
      BAUD_4800: rate = 4800;
      BAUD_9600: rate = 9600;
      default:   rate = 19200;
    endcase
    div = clk_freq / (rate * OS_RATE);
    if (div == 0) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clock os_tick every baud divisor clocks,
// phase-aligned to the start edge via restart.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] baud_rate,
  input  logic       restart,
  output logic       os_tick
);

  // 2400 baud gives the largest divisor and so sets the counter width.
  localparam int unsigned MaxDiv = baud_divisor(BAUD_2400, CLK_FREQ);
  localparam int unsigned CntW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] last;

  // Terminal count for the selected baud rate.
  always_comb begin
    last    = CntW'(baud_divisor(baud_rate, CLK_FREQ) - 1);
    os_tick = (cnt_q == last);
  end

  // Divisor counter, forced back to zero on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == last)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8-bit frames with optional parity, one stop
// bit, per-frame parity/framing flags and a one-cycle valid strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned OS_RATE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // Start bit is checked halfway through; later bits a full bit period apart.
  localparam logic [3:0] MidTick  = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0] LastTick = 4'(OS_RATE - 1);

  logic       sync1_q, rx_s_q, rx_prev_q;
  rx_state_e  state_q;
  logic [3:0] os_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [1:0] baud_q, par_q;
  logic       par_pend_q;

  logic       os_tick;
  logic       start_det;
  logic       par_en;
  logic       par_exp;

  // Start-edge detect and parity expectation from the latched frame settings.
  always_comb begin
    start_det = (state_q == StIdle) && rx_prev_q && !rx_s_q;
    par_en    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    par_exp   = (^shift_q) ^ (par_q == PAR_ODD);
  end

  uart_os_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_os_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_rate (baud_q),
    .restart   (start_det),
    .os_tick   (os_tick)
  );

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      baud_q     <= BAUD_2400;
      par_q      <= PAR_NONE;
      par_pend_q <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q    <= StStart;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            par_pend_q <= 1'b0;
            baud_q     <= baud_rate;
            par_q      <= parity_type;
            busy       <= 1'b1;
          end
        end
        StStart: begin
          if (os_tick) begin
            if (os_cnt_q == MidTick) begin
              os_cnt_q <= '0;
              if (!rx_s_q) begin
                state_q <= StData;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (os_tick) begin
            if (os_cnt_q == LastTick) begin
              os_cnt_q           <= '0;
              shift_q[bit_cnt_q] <= rx_s_q;
              bit_cnt_q          <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7) state_q <= par_en ? StParity : StStop;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (os_tick) begin
            if (os_cnt_q == LastTick) begin
              os_cnt_q   <= '0;
              par_pend_q <= (rx_s_q != par_exp);
              state_q    <= StStop;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (os_tick) begin
            if (os_cnt_q == LastTick) begin
              os_cnt_q   <= '0;
              data_out   <= shift_q;
              parity_err <= par_pend_q;
              frame_err  <= ~rx_s_q;
              rx_valid   <= 1'b1;
              if (rx_s_q) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q <= StWaitIdle;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StWaitIdle: begin
          // Line held low (break): wait for idle so it cannot look like a start.
          if (rx_s_q) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that is the downstream counterpart of the UART transmit path. It samples an asynchronous serial line with 16x oversampling and reassembles 8-bit frames: start bit, 8 data bits LSB first, optional parity bit, one stop bit. Each frame is presented as a parallel byte with a one-cycle valid strobe and per-frame error flags. The same parity_type and baud_rate encodings as the transmit path are used, so a looped-back tx line decodes directly.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive the oversample divisors.
OS_RATE, 16, oversample ticks per bit; fixed at 16, exposed only for reference.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
rx  in  1  serial input; asynchronous to clk; idles high.
baud_rate  in  2  00=2400, 01=4800, 10=9600, 11=19200 baud.
parity_type  in  2  00=none, 01=odd, 10=even, 11=none.
data_out  out  8  last received byte.
rx_valid  out  1  one-cycle pulse when data_out and the error flags update.
parity_err  out  1  received parity mismatch for the current frame.
frame_err  out  1  stop bit sampled low.
busy  out  1  high from accepted start edge until the end of frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE, data_out=8'h00, rx_valid=0, parity_err=0, frame_err=0, busy=0, counters cleared, synchronizer flops set to 1.
- rx passes through a 2-flop synchronizer before any use. All "rx" references below mean the synchronized value.
- Tick generator: divisor = CLK_FREQ/(baud*16), truncated. It produces a one-clk os_tick pulse every divisor clocks.
  - Restarts at 0 on start-edge detection, so phase is aligned to the start edge.
  - baud_rate and parity_type are latched on start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: a 1->0 transition on rx moves to START; tick counter cleared; busy=1.
  - START: on the 8th os_tick, sample rx.
    - 0: go to DATA, tick counter cleared.
    - 1: false start; return to IDLE; busy=0; no rx_valid.
  - DATA: every 16th os_tick, sample rx into shift register bit[bit_cnt], bit 0 first. After bit 7, go to PARITY if latched parity_type is 01 or 10, else STOP.
  - PARITY: sample on the 16th os_tick.
    - Expected bit = XOR of the data bits for even; inverted XOR for odd.
    - Mismatch sets the pending parity error. Go to STOP.
  - STOP: sample on the 16th os_tick (mid stop bit).
    - data_out <= shift register; parity_err <= pending; frame_err <= ~rx; rx_valid=1 for exactly one clk.
    - If rx=1: go to IDLE, busy=0.
    - If rx=0: go to WAIT_IDLE.
  - WAIT_IDLE: hold busy=1 until rx=1, then go to IDLE. This prevents break conditions from retriggering start detection.
- rx_valid is asserted even when errors are flagged. The error flags and data_out hold their values until the next rx_valid.
- Latency: rx_valid occurs about 0.5 bit after the leading edge of the stop bit, i.e. (1+8+P)*16+8 os_ticks after the start edge, where P=1 with parity and 0 without.
- A new start edge is accepted on the clk immediately after returning to IDLE.
- Reset asserted mid-frame aborts immediately. No rx_valid is produced for the partial frame.

Decomposition:
- Package uart_pkg: baud encoding constants, parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN), rx FSM state enum, OS_RATE=16, and a function returning the divisor for a given baud code and CLK_FREQ.
- One sub-module: uart_os_tick. Inputs clk, rst_n, baud_rate, restart; output os_tick; holds the divisor counter.
- Synchronizer, FSM, shift register and parity check stay in uart_rx.

Test Plan:
- Frame 8'hA5, no parity, 9600 baud -> one rx_valid pulse; data_out=8'hA5; parity_err=0; frame_err=0; pulse about 9.5 bit times after the start edge.
- Frame 8'h3C with even parity, correct parity bit 0 -> data_out=8'h3C, parity_err=0. Repeat with the parity bit forced to 1 -> parity_err=1, rx_valid still pulses.
- Frame 8'h81, odd parity, 19200 baud, stop bit driven 0 and held low 3 bit times -> frame_err=1 and busy held high until rx returns to 1. No second rx_valid occurs.
- Low glitch of 4 os_ticks on an idle line -> false start: busy returns to 0, no rx_valid, next valid frame 8'h55 decodes correctly.
- Back-to-back frames 8'h00, 8'hFF, 8'h5A at 2400 baud with no idle gap -> three rx_valid pulses in order with correct data. Also toggle baud_rate mid-frame -> frame unaffected.
- rst_n pulsed low during data bit 4 of 8'hC3 -> all outputs zero, state IDLE, no rx_valid. The following frame 8'h12 is received correctly.
